// File: rtl/ft245_sync_tx.sv
// ft245_sync_tx: FT245 synchronous FIFO transmit path with small FIFO and registered bus stage.
// Optional SIWU# send-immediate pulse after idle is enabled by defining FT_SIWU_EN.
module ft245_sync_tx #(
  parameter int DEPTH_LOG2 = 4,
  parameter int SIWU_IDLE  = 64
) (
  input  logic                  uclk_i,
  input  logic                  reset_i,
  input  logic                  txe_i,
  output logic                  wr_o,
  output logic [7:0]            byte_o,
  output logic                  drv_en_o,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [15:0]           sent_cnt_o,
  output logic                  siwu_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic commit, push, pop, empty, stage_nx;
  // drv_en_o doubles as the output-stage valid flag
  assign commit   = ~wr_o & ~txe_i;
  assign empty    = level_o == '0;
  assign ready_o  = level_o != (DEPTH_LOG2+1)'(DEPTH);
  assign push     = valid_i & ready_o;
  assign pop      = (~drv_en_o | commit) & ~empty;
  assign stage_nx = pop | (drv_en_o & ~commit);
  always_ff @(posedge uclk_i)
    if (push) mem[wp] <= data_i;
  always_ff @(posedge uclk_i) begin
    if (reset_i) begin
      wp         <= '0;
      rp         <= '0;
      level_o    <= '0;
      byte_o     <= 8'h00;
      wr_o       <= 1'b1;
      drv_en_o   <= 1'b0;
      sent_cnt_o <= 16'h0000;
    end else begin
      wp         <= wp + DEPTH_LOG2'(push);
      rp         <= rp + DEPTH_LOG2'(pop);
      level_o    <= level_o + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      if (pop) byte_o <= mem[rp];
      wr_o       <= ~(stage_nx & ~txe_i);
      drv_en_o   <= stage_nx;
      sent_cnt_o <= sent_cnt_o + 16'(commit);
    end
  end
`ifdef FT_SIWU_EN
  localparam int IW = $clog2(SIWU_IDLE + 1);
  logic [IW-1:0] idle;
  logic pend;
  always_ff @(posedge uclk_i) begin
    if (reset_i) begin
      idle   <= '0;
      pend   <= 1'b0;
      siwu_o <= 1'b1;
    end else begin
      siwu_o <= 1'b1;
      if (commit) begin
        idle <= '0;
        pend <= 1'b1;
      end else if (~drv_en_o & empty & (idle != IW'(SIWU_IDLE))) begin
        idle <= idle + IW'(1);
        if (pend & (idle == IW'(SIWU_IDLE - 1))) begin
          siwu_o <= 1'b0;
          pend   <= 1'b0;
        end
      end
    end
  end
`else
  assign siwu_o = 1'b1;
`endif
endmodule
